// File: rtl/polar_common_pkg.sv
// rtl/polar_common_pkg.sv - shared CRC, info-bit mapping and polar transform helpers
package polar_common_pkg;

    localparam int MAX_N   = 1024;
    localparam int CRC_MAX = 24;

    // MSB-first serial LFSR over data[data_w-1:0]; returns 0 when crc_w is 0
    function automatic logic [CRC_MAX-1:0] crc_calc(
        input logic [MAX_N-1:0]   data,
        input int                 data_w,
        input int                 crc_w,
        input logic [CRC_MAX-1:0] poly,
        input logic [CRC_MAX-1:0] init
    );
        logic [CRC_MAX-1:0] mask;
        logic [CRC_MAX-1:0] crc;
        logic               fb;
        mask = (CRC_MAX'(1) << crc_w) - CRC_MAX'(1);
        crc  = init & mask;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (i < data_w && crc_w > 0) begin
                fb  = crc[crc_w-1] ^ data[i];
                crc = (crc << 1) & mask;
                if (fb) begin
                    crc = crc ^ (poly & mask);
                end
            end
        end
        return crc;
    endfunction

    function automatic logic [MAX_N-1:0] build_u_mask(
        input logic [MAX_N-1:0] msg,
        input logic [MAX_N-1:0] info_mask,
        input int               n
    );
        logic [MAX_N-1:0] u;
        int               k;
        u = '0;
        k = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n && info_mask[i]) begin
                u[i] = msg[k];
                k++;
            end
        end
        return u;
    endfunction

    function automatic int bitrev(input int idx, input int log2n);
        int r;
        r = 0;
        for (int b = 0; b < log2n; b++) begin
            r = r | (((idx >> b) & 1) << (log2n - 1 - b));
        end
        return r;
    endfunction

    function automatic int popcount(input logic [MAX_N-1:0] v, input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n && v[i]) begin
                cnt++;
            end
        end
        return cnt;
    endfunction

    function automatic logic [MAX_N-1:0] polar_transform(input logic [MAX_N-1:0] u, input int log2n);
        logic [MAX_N-1:0] v;
        v = u;
        for (int s = 0; s < log2n; s++) begin
            for (int i = 0; i < (1 << log2n); i++) begin
                if (((i >> s) & 1) == 0) begin
                    v[i] = v[i] ^ v[i + (1 << s)];
                end
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/polar_bfly_stage.sv
// rtl/polar_bfly_stage.sv - one combinational polar butterfly stage (distance 2^STAGE)
module polar_bfly_stage
    import polar_common_pkg::*;
#(
    parameter int LOG2N = 6,
    parameter int STAGE = 0
) (
    input  logic [(1<<LOG2N)-1:0] din,
    output logic [(1<<LOG2N)-1:0] dout
);

    localparam int N = 1 << LOG2N;
    localparam int D = 1 << STAGE;

    for (genvar i = 0; i < N; i++) begin : g_bit
        if (((i >> STAGE) & 1) == 0) begin : g_upper
            assign dout[i] = din[i] ^ din[i+D];
        end else begin : g_lower
            assign dout[i] = din[i];
        end
    end

endmodule

// File: rtl/polar_crc_encoder_pipe.sv
// rtl/polar_crc_encoder_pipe.sv - pipelined CRC-aided polar encoder; POLAR_ENC_BITREV_EN selects bit-reversed output order
module polar_crc_encoder_pipe
    import polar_common_pkg::*;
#(
    parameter int                 LOG2N     = 6,
    parameter int                 DATA_W    = 24,
    parameter int                 CRC_W     = 16,
    parameter logic [CRC_MAX-1:0] CRC_POLY  = CRC_MAX'(16'h1021),
    parameter logic [CRC_MAX-1:0] CRC_INIT  = CRC_MAX'(16'hFFFF),
    parameter logic [MAX_N-1:0]   INFO_MASK = MAX_N'(64'hFFFF_FFFF_FF00_0000),
    parameter int                 BFLY_REGS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [(1<<LOG2N)-1:0] out_codeword
);

    localparam int N   = 1 << LOG2N;
    localparam int SPG = (LOG2N + BFLY_REGS - 1) / BFLY_REGS;

    if (LOG2N < 3 || LOG2N > 10) begin : g_bad_log2n
        $fatal(1, "polar_crc_encoder_pipe: LOG2N must be 3..10");
    end
    if (CRC_W != 0 && CRC_W != 8 && CRC_W != 16 && CRC_W != 24) begin : g_bad_crc_w
        $fatal(1, "polar_crc_encoder_pipe: CRC_W must be 0, 8, 16 or 24");
    end
    if (BFLY_REGS < 1 || BFLY_REGS > LOG2N) begin : g_bad_bfly_regs
        $fatal(1, "polar_crc_encoder_pipe: BFLY_REGS must be 1..LOG2N");
    end
    if (popcount(INFO_MASK, N) != DATA_W + CRC_W) begin : g_bad_mask
        $fatal(1, "polar_crc_encoder_pipe: INFO_MASK popcount must equal DATA_W+CRC_W");
    end

    logic                       en;
    logic [CRC_MAX-1:0]         crc;
    logic [MAX_N-1:0]           msg;
    logic [N-1:0]               u_next;
    logic [N-1:0]               u_q;
    logic                       u_valid_q;
    logic [BFLY_REGS:0][N-1:0]  pipe_data;
    logic [BFLY_REGS:0]         pipe_valid;
    logic [LOG2N-1:0][N-1:0]    bf_out;

    // Global stall: the whole pipe freezes whenever the output register is blocked
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = pipe_valid[BFLY_REGS];

    always_comb begin
        crc    = crc_calc(MAX_N'(in_data), DATA_W, CRC_W, CRC_POLY, CRC_INIT);
        msg    = (MAX_N'(in_data) << CRC_W) | MAX_N'(crc);
        u_next = N'(build_u_mask(msg, INFO_MASK, N));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            u_q       <= '0;
            u_valid_q <= 1'b0;
        end else if (en) begin
            u_q       <= u_next;
            u_valid_q <= in_valid;
        end
    end

    assign pipe_data[0]  = u_q;
    assign pipe_valid[0] = u_valid_q;

    // Each butterfly either starts a group (fed by that group's input register) or chains
    for (genvar s = 0; s < LOG2N; s++) begin : g_stage
        logic [N-1:0] bf_in;
        if (s % SPG == 0) begin : g_head
            assign bf_in = pipe_data[s / SPG];
        end else begin : g_chain
            assign bf_in = bf_out[s-1];
        end
        polar_bfly_stage #(
            .LOG2N (LOG2N),
            .STAGE (s)
        ) u_bfly (
            .din  (bf_in),
            .dout (bf_out[s])
        );
    end

    for (genvar g = 0; g < BFLY_REGS; g++) begin : g_grp
        localparam int LAST = (((g + 1) * SPG < LOG2N) ? (g + 1) * SPG : LOG2N) - 1;
        logic [N-1:0] grp_next;
        logic [N-1:0] grp_q;
        logic         grp_valid_q;

        if (g * SPG < LOG2N) begin : g_bfly
            assign grp_next = bf_out[LAST];
        end else begin : g_pass
            assign grp_next = pipe_data[g];
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                grp_q       <= '0;
                grp_valid_q <= 1'b0;
            end else if (en) begin
                grp_q       <= grp_next;
                grp_valid_q <= pipe_valid[g];
            end
        end

        assign pipe_data[g+1]  = grp_q;
        assign pipe_valid[g+1] = grp_valid_q;
    end

`ifdef POLAR_ENC_BITREV_EN
    for (genvar i = 0; i < N; i++) begin : g_bitrev
        assign out_codeword[i] = pipe_data[BFLY_REGS][bitrev(i, LOG2N)];
    end
`else
    assign out_codeword = pipe_data[BFLY_REGS];
`endif

endmodule

// File: tb/tb_polar_crc_encoder_pipe.sv
// tb/tb_polar_crc_encoder_pipe.sv - directed self-checking bench for polar_crc_encoder_pipe
module tb_polar_crc_encoder_pipe;
    import polar_common_pkg::*;

    localparam logic [127:0] MASK_DEF = 128'hFFFF_FFFF_FF00_0000;
    localparam logic [127:0] MASK_D   = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FF00_0000_0000;
    localparam logic [71:0]  DATA_D   = 72'h313233343536373839;
`ifdef POLAR_ENC_BITREV_EN
    localparam logic [15:0]  EXP_C    = 16'h0003;
`else
    localparam logic [15:0]  EXP_C    = 16'h0101;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    logic        s_valid;
    logic [0:0]  s_data;
    logic        s_ready [3];
    logic        s_ov    [3];
    logic [15:0] s_cw    [3];

    logic         d_valid;
    logic [71:0]  d_data;
    logic         d_ready;
    logic         d_ov;
    logic [127:0] d_cw;

    logic        st_valid [2];
    logic [23:0] st_data  [2];
    logic        st_ready [2];
    logic        st_ov    [2];
    logic        st_ordy  [2];
    logic [63:0] st_cw    [2];

    polar_crc_encoder_pipe #(.LOG2N(4), .DATA_W(1), .CRC_W(0), .INFO_MASK(1024'h8000)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s_ready[0]), .in_data(s_data),
        .out_valid(s_ov[0]), .out_ready(1'b1), .out_codeword(s_cw[0]));
    polar_crc_encoder_pipe #(.LOG2N(4), .DATA_W(1), .CRC_W(0), .INFO_MASK(1024'h0001)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s_ready[1]), .in_data(s_data),
        .out_valid(s_ov[1]), .out_ready(1'b1), .out_codeword(s_cw[1]));
    polar_crc_encoder_pipe #(.LOG2N(4), .DATA_W(1), .CRC_W(0), .INFO_MASK(1024'h0100)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s_ready[2]), .in_data(s_data),
        .out_valid(s_ov[2]), .out_ready(1'b1), .out_codeword(s_cw[2]));
    polar_crc_encoder_pipe #(.LOG2N(7), .DATA_W(72), .CRC_W(16),
        .INFO_MASK(1024'hFFFF_FFFF_FFFF_FFFF_FFFF_FF00_0000_0000)) u_dut_d (
        .clk(clk), .rst_n(rst_n), .in_valid(d_valid), .in_ready(d_ready), .in_data(d_data),
        .out_valid(d_ov), .out_ready(1'b1), .out_codeword(d_cw));
    polar_crc_encoder_pipe u_dut_e (
        .clk(clk), .rst_n(rst_n), .in_valid(st_valid[0]), .in_ready(st_ready[0]), .in_data(st_data[0]),
        .out_valid(st_ov[0]), .out_ready(st_ordy[0]), .out_codeword(st_cw[0]));
    polar_crc_encoder_pipe #(.BFLY_REGS(6)) u_dut_f (
        .clk(clk), .rst_n(rst_n), .in_valid(st_valid[1]), .in_ready(st_ready[1]), .in_data(st_data[1]),
        .out_valid(st_ov[1]), .out_ready(st_ordy[1]), .out_codeword(st_cw[1]));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] tb_crc16(input logic [23:0] d);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 23; i >= 0; i--) begin
            c = {c[14:0], 1'b0} ^ (((c[15] ^ d[i]) == 1'b1) ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    function automatic logic [127:0] exp_cw(input logic [127:0] msg, input logic [127:0] mask, input int log2n);
        logic [MAX_N-1:0] u;
        logic [MAX_N-1:0] x;
        logic [127:0]     r;
        int               k;
        u = '0;
        k = 0;
        for (int i = 0; i < (1 << log2n); i++) begin
            if (mask[i]) begin
                u[i] = msg[k];
                k++;
            end
        end
        x = polar_transform(u, log2n);
        r = '0;
        for (int i = 0; i < (1 << log2n); i++) begin
`ifdef POLAR_ENC_BITREV_EN
            r[i] = x[bitrev(i, log2n)];
`else
            r[i] = x[i];
`endif
        end
        return r;
    endfunction

    function automatic logic [63:0] gold_def(input logic [23:0] d);
        logic [127:0] r;
        r = exp_cw({88'h0, d, tb_crc16(d)}, MASK_DEF, 6);
        return r[63:0];
    endfunction

    task automatic run_stream(input int idx, input int n_pay, input int mode);
        logic [63:0] expq [$];
        logic [63:0] held;
        logic        stalled;
        logic        holding;
        int          sent;
        int          got;
        int          cyc;
        stalled = 1'b0;
        holding = 1'b0;
        held    = '0;
        sent    = 0;
        got     = 0;
        cyc     = 0;
        while (got < n_pay && cyc < 2000) begin
            @(negedge clk);
            if (stalled) begin
                check("stall_valid", st_ov[idx], 1'b1);
                check("stall_hold", st_cw[idx], held);
            end
            st_ordy[idx] = (mode == 0) ? !(cyc >= 4 && cyc < 9) : ($urandom_range(0, 3) != 0);
            if (sent < n_pay) begin
                if (!holding) st_data[idx] = 24'($urandom);
                st_valid[idx] = 1'b1;
            end else begin
                st_valid[idx] = 1'b0;
            end
            #1;
            check("ready_rule", st_ready[idx], !st_ov[idx] || st_ordy[idx]);
            if (st_ov[idx] && st_ordy[idx]) begin
                if (expq.size() == 0) check("spurious_out", 1'b1, 1'b0);
                else check("stream_cw", st_cw[idx], expq.pop_front());
                got++;
            end
            if (st_valid[idx] && st_ready[idx]) begin
                expq.push_back(gold_def(st_data[idx]));
                sent++;
                holding = 1'b0;
            end else begin
                holding = st_valid[idx];
            end
            stalled = st_ov[idx] && !st_ordy[idx];
            held    = st_cw[idx];
            cyc++;
        end
        check("stream_count", got, n_pay);
        @(negedge clk);
        st_valid[idx] = 1'b0;
        st_ordy[idx]  = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int stray;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 1'b0;
        d_valid = 1'b0;
        d_data  = '0;
        for (int i = 0; i < 2; i++) begin
            st_valid[i] = 1'b0;
            st_data[i]  = '0;
            st_ordy[i]  = 1'b1;
        end
        repeat (2) @(negedge clk);
        check("rst_out_valid", st_ov[0], 1'b0);
        check("rst_codeword", st_cw[0], 64'h0);
        check("rst_out_valid_f", st_ov[1], 1'b0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", st_ready[0], 1'b1);

        // Single-bit codes: N=16, one information position
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check("small_valid", s_ov[i], 1'b1);
        check("mask_8000", s_cw[0], 16'hFFFF);
        check("mask_0001", s_cw[1], 16'h0001);
        check("mask_0100", s_cw[2], EXP_C);

        // CRC-16 over "123456789"
        check("crc_pkg_check", crc_calc(MAX_N'(DATA_D), 72, 16, 24'h1021, 24'hFFFF), 16'h29B1);
        @(negedge clk);
        d_valid = 1'b1;
        d_data  = DATA_D;
        #1;
        check("crc_in_ready", d_ready, 1'b1);
        @(negedge clk);
        d_valid = 1'b0;
        @(negedge clk);
        check("crc_out_valid", d_ov, 1'b1);
        check("crc_codeword", d_cw, exp_cw({40'h0, DATA_D, 16'h29B1}, MASK_D, 7));

        // Default config, two back-to-back payloads, latency 2
        @(negedge clk);
        st_valid[0] = 1'b1;
        st_data[0]  = 24'h000000;
        #1;
        check("b2b_ready0", st_ready[0], 1'b1);
        @(negedge clk);
        st_data[0] = 24'hABCDEF;
        check("b2b_early", st_ov[0], 1'b0);
        check("b2b_ready1", st_ready[0], 1'b1);
        @(negedge clk);
        st_valid[0] = 1'b0;
        check("b2b_valid0", st_ov[0], 1'b1);
        check("b2b_cw0", st_cw[0], gold_def(24'h000000));
        @(negedge clk);
        check("b2b_valid1", st_ov[0], 1'b1);
        check("b2b_cw1", st_cw[0], gold_def(24'hABCDEF));
        @(negedge clk);
        check("b2b_drained", st_ov[0], 1'b0);

        run_stream(0, 8, 0);

        // BFLY_REGS=6: latency 7
        @(negedge clk);
        st_valid[1] = 1'b1;
        st_data[1]  = 24'h5A5A5A;
        #1;
        check("lat_ready", st_ready[1], 1'b1);
        @(negedge clk);
        st_valid[1] = 1'b0;
        lat = 1;
        while (!st_ov[1] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("lat_f", lat, 7);
        check("lat_f_cw", st_cw[1], gold_def(24'h5A5A5A));
        repeat (2) @(negedge clk);

        run_stream(1, 100, 1);

        // Reset with two blocks in flight
        @(negedge clk);
        st_valid[0] = 1'b1;
        st_data[0]  = 24'h111111;
        @(negedge clk);
        st_data[0] = 24'h222222;
        @(negedge clk);
        st_valid[0] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", st_ov[0], 1'b0);
        check("midrst_cw", st_cw[0], 64'h0);
        rst_n = 1'b1;
        #1;
        check("midrst_ready", st_ready[0], 1'b1);
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (st_ov[0]) stray++;
        end
        check("midrst_no_stale", stray, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
